// File: rtl/direction_detector.sv
// direction_detector
//   Watches the raster-order pixel stream coming out of the frame buffer,
//   counts red-dominant "target" pixels and sums their column indices over
//   one frame. After the last pixel it compares the centroid (sum_x / count,
//   evaluated without a divider) against two column bounds and reports
//   whether the target sits LEFT, CENTRE or RIGHT of the camera view.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   sof           start of frame, qualified by pixel_valid, marks pixel 0
//   pixel_valid   a pixel is present this cycle (no backpressure)
//   pixel         RGB444 pixel, R=[11:8] G=[7:4] B=[3:0]
//   dir           00 NONE, 01 LEFT, 10 CENTRE, 11 RIGHT
//   dir_valid     one-cycle pulse when dir/target_count refresh for a frame
//   target_count  number of target pixels in the last completed frame
//
// Handshake: pixel_valid is a strict valid with no ready; every cycle with
//   pixel_valid=1 is consumed, cycles with pixel_valid=0 are ignored.
//
// Configuration macro: DIR_FILTER_EN
//   When defined, dir only changes when two consecutive frames produce the
//   same raw decision (simple debounce for the robot steering).

module direction_detector #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int PIXEL_BITS   = 12,
  parameter int RED_MIN      = 8,
  parameter int RED_MARGIN   = 4,
  parameter int LEFT_BOUND   = IMAGE_WIDTH / 3,
  parameter int RIGHT_BOUND  = 2 * IMAGE_WIDTH / 3,
  parameter int MIN_PIXELS   = 64
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          sof,
  input  logic                                          pixel_valid,
  input  logic [PIXEL_BITS-1:0]                         pixel,
  output logic [1:0]                                    dir,
  output logic                                          dir_valid,
  output logic [$clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1)-1:0] target_count
);

  localparam int FRAME_PIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CNT_W     = $clog2(FRAME_PIX + 1);
  localparam int COL_W     = $clog2(IMAGE_WIDTH);
  localparam int SUM_W     = $clog2(IMAGE_WIDTH * IMAGE_WIDTH * IMAGE_HEIGHT);
  localparam int CH        = PIXEL_BITS / 3;
  // One extra bit so channel + margin cannot wrap.
  localparam int CW        = CH + 1;
  localparam int PROD_W    = SUM_W + CNT_W;

  localparam logic [1:0] DIR_NONE   = 2'b00;
  localparam logic [1:0] DIR_LEFT   = 2'b01;
  localparam logic [1:0] DIR_CENTRE = 2'b10;
  localparam logic [1:0] DIR_RIGHT  = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, OUTPUT} state_t;

  state_t             state, state_next;
  // Row is not tracked separately: pix_cnt already identifies the last pixel.
  logic [COL_W-1:0]   col;
  logic [CNT_W-1:0]   pix_cnt;
  logic [CNT_W-1:0]   count;
  logic [SUM_W-1:0]   sum_x;
  logic [1:0]         raw_q;
`ifdef DIR_FILTER_EN
  logic [1:0]         prev_raw;
`endif

  // Per-pixel combinational signals
  logic               accept, start, last, hit;
  logic [COL_W-1:0]   base_col;
  logic [CNT_W-1:0]   base_idx;
  logic [CNT_W-1:0]   base_count;
  logic [SUM_W-1:0]   base_sum;
  logic [CW-1:0]      r, g, b;

  // Decision signals
  logic [PROD_W-1:0]  count_p, sum_p, left_th, right_th;
  logic [1:0]         raw;

  assign r = CW'(pixel[3*CH-1:2*CH]);
  assign g = CW'(pixel[2*CH-1:CH]);
  assign b = CW'(pixel[CH-1:0]);

  assign hit = (r >= CW'(RED_MIN)) &&
               (r >= g + CW'(RED_MARGIN)) &&
               (r >= b + CW'(RED_MARGIN));

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (pixel_valid && sof) begin
          accept     = 1'b1;
          start      = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (pixel_valid) begin
          accept = 1'b1;
          start  = sof;   // sof mid-frame drops the partial frame
        end
      end
      DECIDE:  state_next = OUTPUT;
      OUTPUT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // A starting pixel sees zeroed counters/accumulators.
    base_col   = start ? '0 : col;
    base_idx   = start ? '0 : pix_cnt;
    base_count = start ? '0 : count;
    base_sum   = start ? '0 : sum_x;

    last = accept && (base_idx == CNT_W'(FRAME_PIX - 1));
    if (last) state_next = DECIDE;
  end

  // Centroid test without division: sum_x/count < B  <=>  sum_x < count*B.
  always_comb begin
    count_p  = PROD_W'(count);
    sum_p    = PROD_W'(sum_x);
    left_th  = count_p * PROD_W'(LEFT_BOUND);
    right_th = count_p * PROD_W'(RIGHT_BOUND);
    raw      = DIR_CENTRE;
    if (count_p < PROD_W'(MIN_PIXELS))
      raw = DIR_NONE;
    else if (sum_p < left_th)
      raw = DIR_LEFT;
    else if (sum_p >= right_th)
      raw = DIR_RIGHT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      col          <= '0;
      pix_cnt      <= '0;
      count        <= '0;
      sum_x        <= '0;
      raw_q        <= DIR_NONE;
      dir          <= DIR_NONE;
      dir_valid    <= 1'b0;
      target_count <= '0;
`ifdef DIR_FILTER_EN
      prev_raw     <= DIR_NONE;
`endif
    end else begin
      state     <= state_next;
      dir_valid <= (state == OUTPUT);

      if (accept) begin
        col     <= (base_col == COL_W'(IMAGE_WIDTH - 1)) ? '0 : base_col + 1'b1;
        pix_cnt <= base_idx + 1'b1;
        count   <= base_count + CNT_W'(hit);
        sum_x   <= base_sum + (hit ? SUM_W'(base_col) : '0);
      end

      if (state == DECIDE)
        raw_q <= raw;

      if (state == OUTPUT) begin
        target_count <= count;
`ifdef DIR_FILTER_EN
        if (raw_q == prev_raw)
          dir <= raw_q;
        prev_raw <= raw_q;
`else
        dir <= raw_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_direction_detector.sv
module tb_direction_detector;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int TC_W = $clog2(NPIX + 1);
  localparam int EW   = 32 + 2 + TC_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             sof;
  logic             pixel_valid;
  logic [11:0]      pixel;
  logic [1:0]       dir;
  logic             dir_valid;
  logic [TC_W-1:0]  target_count;

  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  logic [11:0]      frame [NPIX];
  logic [EW-1:0]    exp_q[$];

  direction_detector #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .PIXEL_BITS  (12),
    .RED_MIN     (8),
    .RED_MARGIN  (4),
    .LEFT_BOUND  (3),
    .RIGHT_BOUND (5),
    .MIN_PIXELS  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sof         (sof),
    .pixel_valid (pixel_valid),
    .pixel       (pixel),
    .dir         (dir),
    .dir_valid   (dir_valid),
    .target_count(target_count)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver tasks (inputs change 1 time unit after the active edge)
  task automatic send_pix(input logic s, input logic [11:0] p);
    sof         = s;
    pixel_valid = 1'b1;
    pixel       = p;
    @(posedge clk);
    #1;
    sof         = 1'b0;
    pixel_valid = 1'b0;
    pixel       = 12'h000;
  endtask

  task automatic send_range(input int lo, input int hi, input logic with_sof);
    for (int i = lo; i <= hi; i++)
      send_pix(with_sof && (i == lo), frame[i]);
  endtask

  task automatic idle(input int n);
    sof         = 1'b0;
    pixel_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill(input logic [11:0] v);
    for (int i = 0; i < NPIX; i++) frame[i] = v;
  endtask

  // Called right after the last pixel's accepting edge: the pulse is due
  // two edges later.
  task automatic expect_pulse(input logic [1:0] d, input int tc);
    logic [31:0] due;
    due = 32'(cyc + 2);
    exp_q.push_back({due, d, TC_W'(tc)});
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (dir_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: dir_valid=1 with nothing expected (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, int'(e[EW-1:2+TC_W]));
        check("dir", int'(dir), int'(e[1+TC_W:TC_W]));
        check("target_count", int'(target_count), int'(e[TC_W-1:0]));
      end
    end
  end

  initial begin
    reset       = 1'b1;
    sof         = 1'b0;
    pixel_valid = 1'b0;
    pixel       = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_dir", int'(dir), 0);
    check("reset_dir_valid", int'(dir_valid), 0);
    check("reset_target_count", int'(target_count), 0);

    // LEFT: cols 0,1 -> sum 1 < 2*3
    fill(12'h000); frame[0] = 12'hF00; frame[1] = 12'hF00;
    send_range(0, NPIX-1, 1'b1); expect_pulse(2'b01, 2); idle(4);

    // RIGHT: cols 6,7 -> sum 13 >= 10
    fill(12'h000); frame[6] = 12'hF00; frame[7] = 12'hF00;
    send_range(0, NPIX-1, 1'b1); expect_pulse(2'b11, 2); idle(4);

    // CENTRE: cols 3,4 -> sum 7
    fill(12'h000); frame[3] = 12'hF00; frame[4] = 12'hF00;
    send_range(0, NPIX-1, 1'b1); expect_pulse(2'b10, 2); idle(4);

    // NONE: one target, rest 12'h880 fails the margin
    fill(12'h880); frame[0] = 12'hF00;
    send_range(0, NPIX-1, 1'b1); expect_pulse(2'b00, 1); idle(4);
    check("dir_hold", int'(dir), 0);
    check("tc_hold", int'(target_count), 1);

    // Boundary: sum == count*LEFT_BOUND (col 3 twice) -> CENTRE
    fill(12'h000); frame[3] = 12'hF00; frame[11] = 12'hF00;
    send_range(0, NPIX-1, 1'b1); expect_pulse(2'b10, 2); idle(4);

    // Boundary: sum == count*RIGHT_BOUND (col 5 twice) -> RIGHT
    fill(12'h000); frame[5] = 12'hF00; frame[13] = 12'hF00;
    send_range(0, NPIX-1, 1'b1); expect_pulse(2'b11, 2); idle(4);

    // Boundary: sum = count*LEFT_BOUND-1 (cols 2,3) -> LEFT
    fill(12'h000); frame[2] = 12'hF00; frame[3] = 12'hF00;
    send_range(0, NPIX-1, 1'b1); expect_pulse(2'b01, 2); idle(4);

    // Colour-test edges: 840 passes, 740/850/805 fail; targets at col 7 -> RIGHT
    fill(12'h000); frame[0] = 12'h740; frame[1] = 12'h850; frame[2] = 12'h805;
    frame[7] = 12'h840; frame[15] = 12'h840;
    send_range(0, NPIX-1, 1'b1); expect_pulse(2'b11, 2); idle(4);

    // Restart: 10 all-target pixels, then sof again with a LEFT frame
    fill(12'hF00);
    send_range(0, 9, 1'b1);
    fill(12'h000); frame[0] = 12'hF00; frame[1] = 12'hF00;
    send_range(0, NPIX-1, 1'b1); expect_pulse(2'b01, 2); idle(4);

    // Gap of 3 idle cycles mid-frame: CENTRE unchanged, pulse timed off last pixel
    fill(12'h000); frame[3] = 12'hF00; frame[4] = 12'hF00;
    send_range(0, 15, 1'b1); idle(3); send_range(16, NPIX-1, 1'b0);
    expect_pulse(2'b10, 2); idle(4);

    // Reset at pixel 20 discards the frame; trailing pixels without sof ignored
    fill(12'h000); frame[0] = 12'hF00; frame[1] = 12'hF00;
    send_range(0, 19, 1'b1);
    reset = 1'b1; pixel_valid = 1'b1; pixel = frame[20];
    @(posedge clk); #1;
    reset = 1'b0; pixel_valid = 1'b0;
    check("midreset_dir", int'(dir), 0);
    check("midreset_dir_valid", int'(dir_valid), 0);
    check("midreset_target_count", int'(target_count), 0);
    send_range(21, NPIX-1, 1'b0);
    idle(4);
    // New frame: cols 5,6,7 of last row -> sum 18 >= 15 -> RIGHT, count 3
    fill(12'h000); frame[29] = 12'hF00; frame[30] = 12'hF00; frame[31] = 12'hF00;
    send_range(0, NPIX-1, 1'b1); expect_pulse(2'b11, 3);

    // Drain with a bounded wait
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    idle(4);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
